// File: rtl/priority_encoder_seq.sv
// priority_encoder_seq: sequential 16-input priority encoder with a request
// pending register and a valid/ack handshake on the granted code.
// Requests are latched into a pending register. In IDLE, the highest
// eligible pending index is loaded into a and v rises. In PRESENT the code
// is held until ack, which clears that pending bit and returns to IDLE.
// A request that arrives for a bit that is already pending, and is not
// being cleared in that cycle, sets the sticky ovf flag.
// Optional feature: define PRIORITY_ENCODER_MASK_EN to add the per-bit
// eligibility mask input m (1 = eligible).
module priority_encoder_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        e,
    input  logic [15:0] d,
    input  logic        ack,
`ifdef PRIORITY_ENCODER_MASK_EN
    input  logic [15:0] m,
`endif
    output logic [3:0]  a,
    output logic        v,
    output logic        ovf
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pend_q, pend_d;
    logic [3:0]  a_q, a_d;
    logic        ovf_q, ovf_d;

    logic [15:0] eligible;
    logic [15:0] set_vec;
    logic [15:0] clr_vec;
    logic [3:0]  top_idx;
    logic        any_eligible;
    logic        grant_done;

    // Pending bits that may be granted this cycle.
`ifdef PRIORITY_ENCODER_MASK_EN
    assign eligible = pend_q & m;
`else
    assign eligible = pend_q;
`endif

    // Highest set index of the eligible vector.
    always_comb begin
        // NOTE: give every combinational output a default first so no path
        // leaves it unassigned, which would infer a latch.
        top_idx      = 4'd0;
        any_eligible = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (eligible[i]) begin
                top_idx      = 4'(i);
                any_eligible = 1'b1;
            end
        end
    end

    // An acknowledged grant completes only while a code is being presented.
    assign grant_done = (state_q == PRESENT) && ack;
    assign set_vec    = e ? d : 16'h0000;
    assign clr_vec    = grant_done ? (16'h0001 << a_q) : 16'h0000;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge, so it lives inside the
        // clocked branch rather than in the sensitivity list.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: non-blocking assignment so every register updates from
            // the values that existed before the edge.
            state_q <= state_d;
        end
    end

    // Next-state logic: grant when something is eligible, release on ack.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_eligible) state_d = PRESENT;
            PRESENT: if (ack)          state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: v is the state itself, so it is glitch-free and registered.
    always_comb begin
        v   = (state_q == PRESENT);
        a   = a_q;
        ovf = ovf_q;
    end

    // Datapath next values: pending set/clear, code load, overflow detect.
    always_comb begin
        // Set wins over the clear of the bit being acknowledged.
        pend_d = (pend_q & ~clr_vec) | set_vec;
        a_d    = a_q;
        if (state_q == IDLE && any_eligible) begin
            a_d = top_idx;
        end
        ovf_d = ovf_q | (|(set_vec & pend_q & ~clr_vec));
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= 16'h0000;
            a_q    <= 4'h0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            a_q    <= a_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: tb/tb_priority_encoder_seq.sv
// Directed self-checking bench for priority_encoder_seq.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Define PRIORITY_ENCODER_MASK_EN to also exercise the eligibility mask.
module tb_priority_encoder_seq;

    logic        clk;
    logic        rst_n;
    logic        e;
    logic [15:0] d;
    logic        ack;
`ifdef PRIORITY_ENCODER_MASK_EN
    logic [15:0] m;
`endif
    logic [3:0]  a;
    logic        v;
    logic        ovf;

    int vectors     = 0;
    int miscompares = 0;

    priority_encoder_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .e     (e),
        .d     (d),
        .ack   (ack),
`ifdef PRIORITY_ENCODER_MASK_EN
        .m     (m),
`endif
        .a     (a),
        .v     (v),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle before driving or sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic exp_v, input logic [3:0] exp_a,
                             input logic exp_ovf);
        check({tag, ".v"},   {15'd0, v},   {15'd0, exp_v});
        check({tag, ".a"},   {12'd0, a},   {12'd0, exp_a});
        check({tag, ".ovf"}, {15'd0, ovf}, {15'd0, exp_ovf});
    endtask

    initial begin
        rst_n = 1'b0;
        e     = 1'b0;
        d     = 16'h0000;
        ack   = 1'b0;
`ifdef PRIORITY_ENCODER_MASK_EN
        m     = 16'hFFFF;
`endif
        #2;

        // Reset then idle.
        step();
        step();
        check_out("reset", 1'b0, 4'd0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("idle", 1'b0, 4'd0, 1'b0);
        end

        // Single request on bit 5, two-edge latency, held until ack.
        d = 16'h0020; e = 1'b1;
        step();
        d = 16'h0000; e = 1'b0;
        check_out("single.lat1", 1'b0, 4'd0, 1'b0);
        step();
        check_out("single.grant", 1'b1, 4'd5, 1'b0);
        step();
        step();
        check_out("single.hold", 1'b1, 4'd5, 1'b0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check_out("single.ack", 1'b0, 4'd5, 1'b0);
        step();
        check_out("single.after", 1'b0, 4'd5, 1'b0);

        // Priority order 15, 8, 0; ack held high is ignored while v=0.
        d = 16'h8101; e = 1'b1;
        step();
        d = 16'h0000; e = 1'b0;
        step();
        check_out("prio.g15", 1'b1, 4'd15, 1'b0);
        ack = 1'b1;
        step();
        check_out("prio.a15", 1'b0, 4'd15, 1'b0);
        step();
        check_out("prio.g8", 1'b1, 4'd8, 1'b0);
        step();
        check_out("prio.a8", 1'b0, 4'd8, 1'b0);
        step();
        check_out("prio.g0", 1'b1, 4'd0, 1'b0);
        step();
        check_out("prio.a0", 1'b0, 4'd0, 1'b0);
        step();
        check_out("prio.empty", 1'b0, 4'd0, 1'b0);
        ack = 1'b0;

        // Overflow: bit 3 requested again while its grant is unacked.
        d = 16'h0008; e = 1'b1;
        step();
        d = 16'h0000; e = 1'b0;
        step();
        check_out("ovf.grant", 1'b1, 4'd3, 1'b0);
        d = 16'h0008; e = 1'b1;
        step();
        d = 16'h0000; e = 1'b0;
        check_out("ovf.set", 1'b1, 4'd3, 1'b1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
        check_out("ovf.sticky", 1'b0, 4'd3, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_out("ovf.reset", 1'b0, 4'd0, 1'b0);

        // Set wins: bit 3 re-requested in its ack cycle is granted again.
        d = 16'h0008; e = 1'b1;
        step();
        d = 16'h0000; e = 1'b0;
        step();
        check_out("sw.grant1", 1'b1, 4'd3, 1'b0);
        d = 16'h0008; e = 1'b1; ack = 1'b1;
        step();
        d = 16'h0000; e = 1'b0; ack = 1'b0;
        check_out("sw.ack1", 1'b0, 4'd3, 1'b0);
        step();
        check_out("sw.grant2", 1'b1, 4'd3, 1'b0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
        check_out("sw.done", 1'b0, 4'd3, 1'b0);

        // Enable low ignores requests.
        d = 16'h0004; e = 1'b0;
        step();
        d = 16'h0000;
        step();
        check_out("en.off1", 1'b0, 4'd3, 1'b0);
        step();
        check_out("en.off2", 1'b0, 4'd3, 1'b0);

        // Reset mid-grant discards the grant; same-cycle ack has no effect.
        d = 16'h0004; e = 1'b1;
        step();
        d = 16'h0000; e = 1'b0;
        step();
        check_out("rst.grant", 1'b1, 4'd2, 1'b0);
        rst_n = 1'b0; ack = 1'b1;
        step();
        check_out("rst.mid", 1'b0, 4'd0, 1'b0);
        rst_n = 1'b1; ack = 1'b0;
        step();
        step();
        check_out("rst.nogrant", 1'b0, 4'd0, 1'b0);

        // Inputs ignored while reset is held.
        rst_n = 1'b0; d = 16'hFFFF; e = 1'b1;
        step();
        rst_n = 1'b1; d = 16'h0000; e = 1'b0;
        step();
        step();
        check_out("rst.ignore", 1'b0, 4'd0, 1'b0);

`ifdef PRIORITY_ENCODER_MASK_EN
        // Mask: bit 8 stays pending until it becomes eligible.
        m = 16'h00FF;
        d = 16'h0180; e = 1'b1;
        step();
        d = 16'h0000; e = 1'b0;
        step();
        check_out("mask.g7", 1'b1, 4'd7, 1'b0);
        m = 16'h0000;
        step();
        check_out("mask.hold", 1'b1, 4'd7, 1'b0);
        m = 16'h00FF; ack = 1'b1;
        step();
        ack = 1'b0;
        step();
        check_out("mask.blocked", 1'b0, 4'd7, 1'b0);
        m = 16'hFFFF;
        step();
        check_out("mask.g8", 1'b1, 4'd8, 1'b0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
        check_out("mask.done", 1'b0, 4'd8, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/priority_encoder_seq.md
PRIORITY_ENCODER_SEQ -- requirements
Module: priority_encoder_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset is synchronous and active-low.
REQ-003 SHALL have port e, input, 1 bit: request-capture enable; when 0, new requests on d are ignored.
REQ-004 SHALL have port d, input, 16 bits: request lines; d[15] is highest priority, d[0] lowest; a single-cycle pulse is sufficient.
REQ-005 SHALL have port ack, input, 1 bit: consumer acknowledge of the presented code.
REQ-006 SHALL have port a, output, 4 bits: registered binary code of the granted request; a[3] is msb.
REQ-007 SHALL have port v, output, 1 bit: registered valid flag for a.
REQ-008 SHALL have port ovf, output, 1 bit: sticky flag for a request lost because its bit was already pending.
REQ-009 SHALL have port m, input, 16 bits, present only under PRIORITY_ENCODER_MASK_EN: per-bit eligibility mask, 1 = eligible.

Function
REQ-010 SHALL hold a 16-bit pending register pend; when e=1, each d[i]=1 sets pend[i] on the next edge.
REQ-011 SHALL implement a two-state FSM: IDLE (v=0) and PRESENT (v=1).
REQ-012 In IDLE with eligible pend nonzero, SHALL load a with the highest eligible set index, set v=1 and go to PRESENT on the next edge.
REQ-013 In IDLE with no eligible pend bit, SHALL remain in IDLE with v=0; a holds its last value.
REQ-014 In PRESENT, SHALL hold a and v stable until ack=1, even if a higher-priority request arrives.
REQ-015 In PRESENT with ack=1, SHALL clear pend[a], set v=0 and return to IDLE on the next edge; maximum throughput is one grant per 2 cycles.
REQ-016 SHALL ignore ack while v=0.
REQ-017 Latency SHALL be 2 cycles: d[i] is sampled at edge N and v=1 with a=i from edge N+1, when in IDLE with no higher-priority pending bit.
REQ-018 When d[a]=1 and e=1 arrive in the same cycle as a completing ack, set SHALL win: pend[a] stays 1 and ovf is not set.
REQ-019 When d[i]=1 and e=1 arrive while pend[i]=1 and pend[i] is not being cleared that cycle, SHALL set ovf=1; ovf stays set until reset.
REQ-020 Simultaneous requests on multiple bits SHALL all be latched; they are granted in descending index order.
REQ-021 With e=0, existing pending bits SHALL still be granted and acknowledged normally.

Reset
REQ-022 When rst_n=0 at a rising edge, SHALL clear pend to 0, a to 4'h0, v to 0 and ovf to 0, and enter IDLE.
REQ-023 Reset during PRESENT SHALL discard the outstanding grant; an ack in the same cycle has no effect.
REQ-024 While rst_n=0, d, e and ack SHALL be ignored.

Configuration
REQ-025 With macro PRIORITY_ENCODER_MASK_EN defined, the FSM SHALL treat pend[i] as eligible only when m[i]=1; masked bits stay pending and ovf rules are unchanged.
REQ-026 A change to m SHALL NOT alter a grant already held in PRESENT.
REQ-027 Without PRIORITY_ENCODER_MASK_EN, port m SHALL be absent and all pend bits SHALL be eligible.

Verification
REQ-028 Reset then idle: rst_n=0 for 2 cycles, then rst_n=1 with d=0 -> a=0, v=0, ovf=0 on every cycle.
REQ-029 Single request: d=16'h0020 pulsed 1 cycle with e=1 -> v=1 and a=4'd5 two edges later; held until ack; one cycle after ack, v=0.
REQ-030 Priority order: d=16'h8101 in one cycle, ack each grant -> codes 15, 8, 0 in that order, then v=0.
REQ-031 Overflow and set-wins: pend[3] set, d[3] pulsed again while unacked -> ovf=1. In a separate run, d[3] pulsed in the ack cycle of grant 3 -> ovf=0 and code 3 is granted again.
REQ-032 Enable and reset mid-grant: d=16'h0004 with e=0 -> v stays 0. Then d[2] is captured with e=1, and rst_n=0 is applied while v=1 -> v=0 and pend clears; no grant follows after release.
REQ-033 Mask build: m=16'h00FF, d=16'h0180 -> a=7 is granted; bit 8 is not granted until m[8]=1.
